// File: rtl/seq_row_multiplier_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_pkg (package)
// Purpose  : Shared types and constants for the sequential shift-add
//            multiplier controller: FSM state encoding, default operand
//            widths and the product-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

    localparam int c_m_width_default = 3;
    localparam int c_q_width_default = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Unsigned M x Q product never needs more than M+Q bits.
    function automatic int prod_width(input int m_width, input int q_width);
        return m_width + q_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_row_multiplier_ctrl_row.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_row
// Purpose  : One row of remaining-row multiplier cells. Adds (q ? m : 0) to
//            the partial-product vector pp with a ripple carry. Purely
//            combinational.
// Ports    : m    in  M_WIDTH  multiplicand bits (one per cell)
//            q    in  1        current multiplier bit
//            pp   in  M_WIDTH  incoming partial product
//            sum  out M_WIDTH  sum bits
//            cout out 1        carry out of the top cell
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_row
    import seq_mult_pkg::*;
#(
    parameter int M_WIDTH = c_m_width_default
) (
    input  logic [M_WIDTH-1:0] m,
    input  logic               q,
    input  logic [M_WIDTH-1:0] pp,
    output logic [M_WIDTH-1:0] sum,
    output logic               cout
);

    logic [M_WIDTH:0] w_carry;

    assign w_carry[0] = 1'b0;

    generate
        for (genvar i = 0; i < M_WIDTH; i++) begin : g_cell
            logic w_term;
            assign w_term         = m[i] & q;
            assign sum[i]         = w_term ^ pp[i] ^ w_carry[i];
            assign w_carry[i + 1] = (w_term & pp[i]) | (w_carry[i] & (w_term ^ pp[i]));
        end
    endgenerate

    assign cout = w_carry[M_WIDTH];

endmodule
`default_nettype wire

// File: rtl/seq_row_multiplier_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_row_multiplier_ctrl
// Purpose  : Sequential shift-add multiplier controller. Reuses a single
//            multiplier_row, consuming one multiplier bit per cycle, and owns
//            the start/ready/done handshake, accumulator and bit counter.
// Ports    : clock   in  1              system clock (rising edge)
//            reset   in  1              asynchronous, active-high reset
//            start   in  1              request, accepted when ready=1
//            m_in    in  M_WIDTH        multiplicand, sampled on accept
//            q_in    in  Q_WIDTH        multiplier, sampled on accept
//            ready   out 1              can accept start
//            busy    out 1              multiplication in progress
//            done    out 1              one-cycle product-valid pulse
//            product out M_WIDTH+Q_WIDTH result, held until next done
// Macro    : SEQ_MULT_BACK_TO_BACK_EN - accept a new start in DONE
// Revision : 1.0 - initial release
// ============================================================================
module seq_row_multiplier_ctrl
    import seq_mult_pkg::*;
#(
    parameter int M_WIDTH = c_m_width_default,
    parameter int Q_WIDTH = c_q_width_default
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [M_WIDTH-1:0]         m_in,
    input  logic [Q_WIDTH-1:0]         q_in,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [M_WIDTH+Q_WIDTH-1:0] product
);

    localparam int c_p_width   = prod_width(M_WIDTH, Q_WIDTH);
    localparam int c_cnt_width = $clog2(Q_WIDTH) + 1;
    localparam logic [c_cnt_width-1:0] c_last_count = c_cnt_width'(Q_WIDTH - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [M_WIDTH-1:0]     r_m;
    logic [Q_WIDTH-1:0]     r_q;
    logic [c_p_width-1:0]   r_acc;
    logic [c_p_width-1:0]   r_product;
    logic [c_cnt_width-1:0] r_count;

    logic                   w_accept;
    logic                   w_last_bit;
    logic [Q_WIDTH-1:0]     w_q_sel;
    logic                   w_q_bit;
    logic [M_WIDTH-1:0]     w_sum;
    logic                   w_cout;
    logic [c_p_width:0]     w_acc_wide;
    logic [c_p_width-1:0]   w_acc_next;
    logic                   w_unused_lsb;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
`ifdef SEQ_MULT_BACK_TO_BACK_EN
    assign ready = (r_state == IDLE) || (r_state == DONE);
`else
    assign ready = (r_state == IDLE);
`endif
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign product  = r_product;
    assign w_accept = start & ready;

    // ------------------------------------------------------------------
    // Datapath: select current multiplier bit, add into upper acc bits
    // ------------------------------------------------------------------
    // One-hot select avoids a variable part-select wider than the index.
    assign w_q_sel = Q_WIDTH'(1) << r_count;
    assign w_q_bit = |(r_q & w_q_sel);

    multiplier_row #(
        .M_WIDTH (M_WIDTH)
    ) u_row (
        .m    (r_m),
        .q    (w_q_bit),
        .pp   (r_acc[c_p_width-1:Q_WIDTH]),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Carry becomes the new MSB; everything shifts right by one and the
    // lowest accumulator bit falls off (it was already a settled bit that
    // has moved beyond position 0 of the final product window).
    assign w_acc_wide   = {w_cout, w_sum, r_acc[Q_WIDTH-1:0]};
    assign w_acc_next   = w_acc_wide[c_p_width:1];
    assign w_unused_lsb = w_acc_wide[0];

    assign w_last_bit = (r_state == RUN) && (r_count == c_last_count);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = RUN;
            RUN:     if (w_last_bit) w_state_next = DONE;
            // w_accept can only be set here with back-to-back enabled.
            DONE:    w_state_next = w_accept ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, accumulator, counter and product registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_m       <= '0;
            r_q       <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            if (w_accept) begin
                r_m     <= m_in;
                r_q     <= q_in;
                r_acc   <= '0;
                r_count <= '0;
            end else if (r_state == RUN) begin
                r_acc   <= w_acc_next;
                r_count <= r_count + c_cnt_width'(1);
            end
            // Load on the edge that enters DONE so done and the new
            // product appear in the same cycle.
            if (w_last_bit) begin
                r_product <= w_acc_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_row_multiplier_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_row_multiplier_ctrl
// Purpose  : Self-checking bench for seq_row_multiplier_ctrl (default widths
//            M=3, Q=2). Expected products are queued when a start is
//            accepted and compared when done pulses.
// Macro    : SEQ_MULT_BACK_TO_BACK_EN - changes expected back-to-back period
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_row_multiplier_ctrl;

    localparam int M = 3;
    localparam int Q = 2;
`ifdef SEQ_MULT_BACK_TO_BACK_EN
    localparam int PERIOD = Q + 1;
`else
    localparam int PERIOD = Q + 2;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [M-1:0] m_in  = '0;
    logic [Q-1:0] q_in  = '0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [M+Q-1:0] product;

    int checks   = 0;
    int failures = 0;
    logic [M+Q-1:0] exp_q[$];
    logic [M+Q-1:0] last_product = '0;

    seq_row_multiplier_ctrl #(
        .M_WIDTH (M),
        .Q_WIDTH (Q)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .m_in    (m_in),
        .q_in    (q_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, wait for done, compare against scoreboard.
    task automatic do_op(input string tag, input logic [M-1:0] m, input logic [Q-1:0] q);
        int cyc;
        logic [M+Q-1:0] e;
        @(negedge clock);
        check({tag, "_ready"}, {7'b0, ready}, 8'd1);
        start = 1'b1;
        m_in  = m;
        q_in  = q;
        exp_q.push_back(5'({2'b0, m} * {3'b0, q}));
        @(posedge clock); #1;
        start = 1'b0;
        m_in  = 3'($urandom);
        q_in  = 2'($urandom);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            check({tag, "_held"}, {3'b0, product}, {3'b0, last_product});
            @(posedge clock); #1;
            cyc++;
        end
        check({tag, "_latency"}, 8'(cyc), 8'(Q));
        check({tag, "_sb"}, 8'(exp_q.size()), 8'd1);
        e = exp_q.pop_front();
        check({tag, "_product"}, {3'b0, product}, {3'b0, e});
        check({tag, "_busy"}, {7'b0, busy}, 8'd1);
        last_product = e;
        @(posedge clock); #1;
        check({tag, "_pulse"}, {7'b0, done}, 8'd0);
        check({tag, "_keep"}, {3'b0, product}, {3'b0, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int first_t;
        int second_t;
        int saw_done;
        logic [M+Q-1:0] e;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready",   {7'b0, ready}, 8'd1);
        check("rst_busy",    {7'b0, busy},  8'd0);
        check("rst_done",    {7'b0, done},  8'd0);
        check("rst_product", {3'b0, product}, 8'd0);
        @(negedge clock);
        reset = 1'b0;

        // Main function
        do_op("m3q3", 3'd3, 2'd3);
        do_op("m7q3", 3'd7, 2'd3);
        do_op("m5q2", 3'd5, 2'd2);
        do_op("m0q3", 3'd0, 2'd3);
        do_op("m5q0", 3'd5, 2'd0);
        do_op("m6q1", 3'd6, 2'd1);

        // Start held high for 6 edges: expect two products of 7.
        @(negedge clock);
        start = 1'b1;
        m_in  = 3'd7;
        q_in  = 2'd1;
        exp_q.push_back(5'd7);
        exp_q.push_back(5'd7);
        pulses   = 0;
        first_t  = -1;
        second_t = -1;
        for (int t = 0; t < 12; t++) begin
            @(posedge clock); #1;
            if (t == 5) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (first_t < 0) first_t = t;
                else if (second_t < 0) second_t = t;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("hold_product", {3'b0, product}, {3'b0, e});
                end
            end
        end
        check("hold_pulses", 8'(pulses), 8'd2);
        check("hold_gap", 8'(second_t - first_t), 8'(PERIOD));
        last_product = 5'd7;

        // Reset during the second RUN cycle.
        @(negedge clock);
        start = 1'b1;
        m_in  = 3'd7;
        q_in  = 2'd3;
        exp_q.push_back(5'd21);
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        check("mid_busy", {7'b0, busy}, 8'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_ready",   {7'b0, ready}, 8'd1);
        check("mid_rst_busy",    {7'b0, busy},  8'd0);
        check("mid_rst_done",    {7'b0, done},  8'd0);
        check("mid_rst_product", {3'b0, product}, 8'd0);
        exp_q.delete();
        last_product = '0;
        @(negedge clock);
        reset = 1'b0;
        saw_done = 0;
        repeat (5) begin
            @(posedge clock); #1;
            if (done === 1'b1) saw_done = 1;
        end
        check("mid_no_done", 8'(saw_done), 8'd0);

        // Product held at 21 through the next run, then becomes 2.
        do_op("m7q3b", 3'd7, 2'd3);
        do_op("m2q1",  3'd2, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
